// File: rtl/comb_seq_pkg.sv
// ============================================================================
//  Package     : comb_seq_pkg
//  Description : Shared triple type and or-consistency helper for stage 13.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comb_seq_pkg;

  localparam int unsigned TRIPLE_WIDTH = 4;

  typedef struct packed {
    logic [TRIPLE_WIDTH-1:0] a;
    logic [TRIPLE_WIDTH-1:0] b;
    logic [TRIPLE_WIDTH-1:0] o;
  } triple_t;

  function automatic logic or_consistent(input triple_t t);
    return t.o == (t.a | t.b);
  endfunction

endpackage : comb_seq_pkg

`default_nettype wire

// File: rtl/seq_always_fifo_mem.sv
// ============================================================================
//  Module      : seq_always_fifo_mem
//  Description : DEPTH x triple_t register array, sync write, comb read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_always_fifo_mem
  import comb_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  triple_t          i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output triple_t          o_rdata
);

  triple_t r_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[gi] <= '0;
      end else if (i_we && (i_waddr == PTR_W'(gi))) begin
        r_mem[gi] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : seq_always_fifo_mem

`default_nettype wire

// File: rtl/seq_always_stage13_pipe.sv
// ============================================================================
//  Module      : seq_always_stage13_pipe
//  Description : Valid/ready FIFO for {a,b,or} triples with sticky or-check
//                error and XOR accumulator of popped or-values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_always_stage13_pipe
  import comb_seq_pkg::*;
#(
  parameter int unsigned WIDTH = TRIPLE_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH-1:0]         i_in_a,
  input  logic [WIDTH-1:0]         i_in_b,
  input  logic [WIDTH-1:0]         i_in_or,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH-1:0]         o_out_a,
  output logic [WIDTH-1:0]         o_out_b,
  output logic [WIDTH-1:0]         o_out_or,
  output logic [WIDTH-1:0]         o_acc,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err
);

  localparam int unsigned          c_PTR_W = $clog2(DEPTH);
  localparam int unsigned          c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(DEPTH);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_acc;
  logic               r_err;

  logic               w_push;
  logic               w_pop;
  logic               w_we;
  triple_t            w_wdata;
  triple_t            w_head;

  // Handshake depends only on registered occupancy, never on the peer's strobe.
  assign o_in_ready  = (r_count != c_FULL);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid  & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_we        = w_push & ~i_clear;
  assign w_wdata     = '{a: i_in_a, b: i_in_b, o: i_in_or};

  seq_always_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (c_PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_acc <= r_acc ^ w_head.o;
      end
      if (w_push && !or_consistent(w_wdata)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_out_a  = w_head.a;
  assign o_out_b  = w_head.b;
  assign o_out_or = w_head.o;
  assign o_acc    = r_acc;
  assign o_count  = r_count;
  assign o_err    = r_err;

endmodule : seq_always_stage13_pipe

`default_nettype wire
